ex_div_seq: RTL

Iterative divide sequencer for the execute stage. It accepts one DIV/DIVU/REM/REMU or W-variant operation, asserts a stall request that freezes the pipeline, and runs one restoring shift-subtract step per cycle. It then presents the RISC-V-correct quotient or remainder for one cycle, and the held instruction advances into the EX/MA register with that value. It owns the execute stall for division; the ALU stays single-cycle.

---
 rtl/ex_div_seq.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/ex_div_seq.sv
`timescale 1ns/1ps
// Iterative restoring divider for EX: DIV/DIVU/REM/REMU and W variants, one quotient bit per cycle.
// Latency 65 cycles (64-bit) or 33 (W); optional DIV_EARLY_OUT_EN finishes div-by-zero/overflow in 1.
module ex_div_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        start,
    input  logic        is_signed,
    input  logic        is_rem,
    input  logic        is_word,
    input  logic [63:0] dividend,
    input  logic [63:0] divisor,
    output logic        stall_req,
    output logic        done,
    output logic [63:0] result
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state_q, state_d;
    logic [6:0]  cnt_q, cnt_d;
    logic [63:0] rem_q, rem_d;
    logic [63:0] quo_q, quo_d;
    logic [63:0] dvs_q, dvs_d;
    logic        negq_q, negq_d;
    logic        negr_q, negr_d;
    logic        remop_q, remop_d;
    logic        word_q, word_d;

    logic [63:0] a_ext, b_ext, a_mag, b_mag;
    logic        a_neg, b_neg, div_zero;
    logic        q_msb, ge;
    logic [64:0] rem_sh, diff;
    logic [63:0] q_fix, r_fix, sel;

    always_comb begin
        a_ext    = is_word ? {{32{is_signed & dividend[31]}}, dividend[31:0]} : dividend;
        b_ext    = is_word ? {{32{is_signed & divisor[31]}},  divisor[31:0]}  : divisor;
        a_neg    = is_signed & a_ext[63];
        b_neg    = is_signed & b_ext[63];
        a_mag    = a_neg ? 64'd0 - a_ext : a_ext;
        b_mag    = b_neg ? 64'd0 - b_ext : b_ext;
        div_zero = (b_ext == 64'd0);
    end

`ifdef DIV_EARLY_OUT_EN
    logic ovf;
    assign ovf = is_signed & (b_ext == {64{1'b1}}) &
                 (a_ext == (is_word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
`endif

    // 65-bit partial remainder so divisors with bit 63 set still compare correctly
    always_comb begin
        q_msb  = word_q ? quo_q[31] : quo_q[63];
        rem_sh = {rem_q, q_msb};
        diff   = rem_sh - {1'b0, dvs_q};
        ge     = ~diff[64];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        remop_d = remop_q;
        word_d  = word_q;
        case (state_q)
            IDLE: begin
                if (start && !clear) begin
                    state_d = RUN;
                    cnt_d   = is_word ? 7'd32 : 7'd64;
                    rem_d   = 64'd0;
                    quo_d   = a_mag;
                    dvs_d   = b_mag;
                    // x/0 must give all-ones regardless of dividend sign
                    negq_d  = (a_neg ^ b_neg) & ~div_zero;
                    negr_d  = a_neg;
                    remop_d = is_rem;
                    word_d  = is_word;
`ifdef DIV_EARLY_OUT_EN
                    if (div_zero) begin
                        state_d = DONE;
                        quo_d   = {64{1'b1}};
                        rem_d   = a_mag;
                    end else if (ovf) begin
                        state_d = DONE;
                        quo_d   = a_mag;
                        rem_d   = 64'd0;
                    end
`endif
                end
            end
            RUN: begin
                rem_d = ge ? diff[63:0] : rem_sh[63:0];
                quo_d = {quo_q[62:0], ge};
                cnt_d = cnt_q - 7'd1;
                if (cnt_q == 7'd1) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (clear) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 7'd0;
            rem_q   <= 64'd0;
            quo_q   <= 64'd0;
            dvs_q   <= 64'd0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            remop_q <= 1'b0;
            word_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            remop_q <= remop_d;
            word_q  <= word_d;
        end
    end

    always_comb begin
        q_fix     = negq_q ? 64'd0 - quo_q : quo_q;
        r_fix     = negr_q ? 64'd0 - rem_q : rem_q;
        sel       = remop_q ? r_fix : q_fix;
        done      = (state_q == DONE);
        result    = 64'd0;
        if (done) result = word_q ? {{32{sel[31]}}, sel[31:0]} : sel;
        stall_req = rst_n & ~clear & (((state_q == IDLE) & start) | (state_q == RUN));
    end

endmodule
